nway_l2_cache: RTL and testbench
================================

NWAY_L2_CACHE -- requirements
Module: nway_l2_cache

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes.
- s_index, 3, set-index bits; num_sets = 2**s_index.
- num_ways, 4, associativity; power of two, >= 2.
- s_tag, 32-s_offset-s_index, tag width (derived).

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock; all state changes on rising edge.
- rst, in, 1, asynchronous, active-high reset.
- mem_address, in, 32, CPU-side line address.
- mem_read, in, 1, CPU read request.
- mem_write, in, 1, CPU write request.
- mem_byte_enable256, in, 32, per-byte write mask.
- mem_wdata256, in, 256, write line.
- mem_rdata256, out, 256, read line.
- mem_resp, out, 1, one-cycle completion pulse.
- pmem_address, out, 32, memory-side address, low s_offset bits zero.
- pmem_read, out, 1, line fill request.
- pmem_write, out, 1, line writeback request.
- pmem_wdata, out, 256, writeback line.
- pmem_rdata, in, 256, fill line.
- pmem_resp, in, 1, memory completion pulse.

Function
REQ-003 Storage per way SHALL be: tag, valid, dirty and data arrays of num_sets entries, combinational read, indexed by mem_address[s_offset+s_index-1:s_offset]; one tree-PLRU vector of num_ways-1 bits per set.
REQ-004 FSM states SHALL be IDLE, COMPARE, WRITEBACK and FILL.
REQ-005 IDLE: when mem_read|mem_write is sampled, the next state SHALL be COMPARE; otherwise remain in IDLE.
REQ-006 way w SHALL hit when valid[w] and tag[w] == mem_address tag; at most one way hits.
REQ-007 COMPARE on hit SHALL assert mem_resp for exactly one cycle and drive mem_rdata256 from the hit way; a write SHALL merge mem_wdata256 under mem_byte_enable256 and set dirty; the PLRU SHALL update; the next state is IDLE. Hit latency is one cycle after request sample.
REQ-008 Victim SHALL be the lowest-numbered invalid way, or, if all ways are valid, the PLRU victim.
REQ-009 PLRU walk: node 0 is the root; children of node n are 2n+1 and 2n+2; bit 0 selects the lower half and bit 1 the upper half.
REQ-010 PLRU update: an access to way w SHALL set every node on w's path to point away from w.
REQ-011 COMPARE on miss SHALL go to WRITEBACK if the victim is valid and dirty, otherwise to FILL; mem_resp SHALL stay 0.
REQ-012 WRITEBACK SHALL hold pmem_write=1, pmem_address={victim tag, index, 0} and pmem_wdata=victim data until pmem_resp, then go to FILL.
REQ-013 FILL SHALL hold pmem_read=1 with pmem_address={mem_address[31:s_offset], 0} until pmem_resp. On pmem_resp it SHALL write pmem_rdata into the victim, set tag, set valid=1 and dirty=0, then return to COMPARE. That COMPARE hits.
REQ-014 pmem_read and pmem_write SHALL never be asserted together, and SHALL be 0 in IDLE and COMPARE.
REQ-015 If mem_read and mem_write are both asserted, the request SHALL be treated as a write.
REQ-016 CPU request signals SHALL be held stable until mem_resp; behaviour otherwise is undefined.
REQ-017 pmem_resp outside WRITEBACK or FILL SHALL be ignored.
REQ-018 The PLRU SHALL not change on a miss until the refill COMPARE hit.

Reset
REQ-019 rst SHALL asynchronously force state IDLE and clear all valid, dirty and PLRU bits. It SHALL drive mem_resp, pmem_read and pmem_write to 0 immediately, including mid-WRITEBACK or mid-FILL, with no array write. Data and tag contents are don't-care.
REQ-020 After reset release, the first access to any set SHALL miss and fill way 0.

Verification
REQ-021 Cold read 0x0000_0100 -> FILL with pmem_address 0x0000_0100, fill into way 0, mem_resp 1 cycle after the COMPARE following pmem_resp; re-read hits with resp 1 cycle after sample.
REQ-022 Write hit at 0x100 with byte_enable 0x0000_000F, wdata low word 0xDEADBEEF -> only bytes 0-3 change; dirty[way0] set; read returns merged line.
REQ-023 Five distinct tags in set 0 (0x000, 0x100, ..., 0x400), num_ways=4 -> ways 0-3 fill in order; the fifth access evicts the PLRU victim way 0 after an intervening hit to way 2 is accounted for, matching a reference tree model.
REQ-024 Eviction of a dirty way holding tag 0x000001 in set 0 -> WRITEBACK with pmem_address 0x0000_0100 and correct pmem_wdata before FILL; pmem_read/pmem_write never overlap.
REQ-025 rst pulsed mid-FILL -> pmem_read drops the same cycle; a subsequent read of the same address misses.
REQ-026 num_ways=2 and num_ways=8 builds -> REQ-021 to REQ-024 pass with a single-bit and a 7-bit PLRU respectively.

Source files
------------

// File: rtl/nway_l2_cache.sv
// N-way set-associative write-back L2 cache.
// Tree-PLRU replacement, one line per request.
module nway_l2_cache #(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 4,
  parameter int s_tag    = 32 - s_offset - s_index
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_byte_enable256,
  input  logic [255:0] mem_wdata256,
  output logic [255:0] mem_rdata256,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int num_sets = 2 ** s_index;
  localparam int lw = $clog2(num_ways);
  localparam int np = num_ways - 1;

  typedef enum logic [1:0] {
    IDLE, COMPARE, WRITEBACK, FILL
  } state_t;

  state_t state_q, state_d;

  logic [s_tag-1:0]    tag_a  [num_ways][num_sets];
  logic [255:0]        data_a [num_ways][num_sets];
  logic [num_ways-1:0] valid_a [num_sets];
  logic [num_ways-1:0] dirty_a [num_sets];
  logic [np-1:0]       plru_a  [num_sets];

  logic [s_index-1:0] idx;
  logic [s_tag-1:0]   tg;
  logic               hit;
  logic [lw-1:0]      hit_way;
  logic [lw-1:0]      plru_vic;
  logic [lw-1:0]      victim;
  logic [np-1:0]      plru_upd;
  logic [255:0]       merged;
  logic               vic_dirty;

  assign idx = mem_address[s_offset+s_index-1:s_offset];
  assign tg  = mem_address[31 -: s_tag];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < num_ways; w++) begin
      if (valid_a[idx][w] && tag_a[w][idx] == tg) begin
        hit = 1'b1;
        hit_way = lw'(w);
      end
    end
  end

  // Victim: lowest invalid way, else walk the PLRU tree.
  always_comb begin
    int n;
    n = 0;
    for (int l = 0; l < lw; l++) begin
      n = 2 * n + 1 + int'(plru_a[idx][n]);
    end
    plru_vic = lw'(n - np);
    victim = plru_vic;
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_a[idx][w]) victim = lw'(w);
    end
  end

  // Point every node on the hit way's path away from it.
  always_comb begin
    int n;
    int p;
    p = 0;
    plru_upd = plru_a[idx];
    n = int'(hit_way) + np;
    for (int l = 0; l < lw; l++) begin
      p = (n - 1) / 2;
      plru_upd[p] = (n == 2 * p + 1);
      n = p;
    end
  end

  // Byte-masked merge of the write line into the hit line.
  always_comb begin
    merged = data_a[hit_way][idx];
    for (int b = 0; b < 32; b++) begin
      if (mem_byte_enable256[b])
        merged[b*8 +: 8] = mem_wdata256[b*8 +: 8];
    end
  end

  assign mem_rdata256 = data_a[hit_way][idx];
  assign pmem_wdata   = data_a[victim][idx];
  assign vic_dirty    = valid_a[idx][victim]
                      & dirty_a[idx][victim];

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    mem_resp = 1'b0;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = {mem_address[31:s_offset],
                    {s_offset{1'b0}}};
    unique case (state_q)
      IDLE: begin
        if (mem_read | mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          mem_resp = 1'b1;
          state_d = IDLE;
        end else if (vic_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        pmem_address = {tag_a[victim][idx], idx,
                        {s_offset{1'b0}}};
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Valid, dirty and PLRU bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < num_sets; s++) begin
        valid_a[s] <= '0;
        dirty_a[s] <= '0;
        plru_a[s]  <= '0;
      end
    end else if (state_q == COMPARE && hit) begin
      plru_a[idx] <= plru_upd;
      if (mem_write) dirty_a[idx][hit_way] <= 1'b1;
    end else if (state_q == FILL && pmem_resp) begin
      valid_a[idx][victim] <= 1'b1;
      dirty_a[idx][victim] <= 1'b0;
    end
  end

  // Tag and data arrays; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == COMPARE && hit && mem_write) begin
        data_a[hit_way][idx] <= merged;
      end else if (state_q == FILL && pmem_resp) begin
        data_a[victim][idx] <= pmem_rdata;
        tag_a[victim][idx]  <= tg;
      end
    end
  end

endmodule

// File: tb/tb_nway_l2_cache.sv
// Scoreboard bench for nway_l2_cache.
// Directed accesses, memory responder, response monitor.
module tb_nway_l2_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] mem_wdata256;
  logic [255:0] mem_rdata256;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  nway_l2_cache dut (
    .clk(clk),
    .rst(rst),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256),
    .mem_wdata256(mem_wdata256),
    .mem_rdata256(mem_rdata256),
    .mem_resp(mem_resp),
    .pmem_address(pmem_address),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp)
  );

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } pexp_t;

  typedef struct {
    logic         chk;
    logic [255:0] data;
  } rexp_t;

  pexp_t pq[$];
  rexp_t rq[$];
  logic [255:0] shadow [logic [31:0]];

  int  checks = 0;
  int  errors = 0;
  bit  hold = 1'b0;
  int  pcnt = 0;

  function automatic logic [255:0] fill_line(
    input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++)
      l[i*32 +: 32] = a ^ 32'hA5A5_0000 ^ (32'(i) << 24);
    return l;
  endfunction

  function automatic logic [255:0] line_of(
    input logic [31:0] a);
    if (!shadow.exists(a)) shadow[a] = fill_line(a);
    return shadow[a];
  endfunction

  task automatic check(input string nm,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory side: respond after three cycles, check traffic.
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if ((pmem_read || pmem_write) && !hold && !rst) begin
        pcnt++;
        if (pcnt == 3) begin
          pexp_t e;
          pcnt = 0;
          check("pmem_overlap", pmem_read && pmem_write, 0);
          checks++;
          if (pq.size() == 0) begin
            errors++;
            $display("FAIL pmem_unexpected: addr %h wr %0b",
                     pmem_address, pmem_write);
          end else begin
            e = pq.pop_front();
            check("pmem_write", pmem_write, e.wr);
            check("pmem_addr", pmem_address, e.addr);
            if (e.wr) check("pmem_wdata", pmem_wdata, e.data);
          end
          pmem_rdata = fill_line(pmem_address);
          pmem_resp = 1'b1;
        end
      end else begin
        pcnt = 0;
      end
    end
  end

  // CPU side monitor: every mem_resp pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        rexp_t r;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected: rdata %h", mem_rdata256);
        end else begin
          r = rq.pop_front();
          if (r.chk) check("rdata", mem_rdata256, r.data);
        end
      end
    end
  end

  task automatic access(input logic [31:0] a,
                        input logic rd,
                        input logic wr,
                        input logic [31:0] be,
                        input logic [255:0] wd,
                        input bit exp_hit,
                        input bit exp_wb,
                        input logic [31:0] wb_a);
    logic [31:0]  ln;
    logic [255:0] t;
    int n;
    bit got;
    ln = {a[31:5], 5'b0};
    if (exp_wb) pq.push_back('{1'b1, wb_a, line_of(wb_a)});
    if (!exp_hit) pq.push_back('{1'b0, ln, '0});
    rq.push_back('{rd && !wr, line_of(ln)});
    if (wr) begin
      t = line_of(ln);
      for (int b = 0; b < 32; b++)
        if (be[b]) t[b*8 +: 8] = wd[b*8 +: 8];
      shadow[ln] = t;
    end
    @(negedge clk);
    mem_address = a;
    mem_read = rd;
    mem_write = wr;
    mem_byte_enable256 = be;
    mem_wdata256 = wd;
    n = 0;
    got = 1'b0;
    while (n < 100 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      got = mem_resp;
    end
    check("resp_seen", got, 1);
    check("hit_latency", n == 1, exp_hit);
    check("pmem_drained", pq.size(), 0);
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    logic [255:0] wd;
    bit seen;
    rst = 1'b1;
    mem_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable256 = '0;
    mem_wdata256 = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_resp", mem_resp, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    rst = 1'b0;
    @(negedge clk);

    wd = '0;
    wd[31:0] = 32'hDEADBEEF;
    access(32'h100, 1, 0, 0, 0, 0, 0, 0);
    access(32'h100, 1, 0, 0, 0, 1, 0, 0);
    access(32'h100, 0, 1, 32'h0000_000F, wd, 1, 0, 0);
    access(32'h100, 1, 0, 0, 0, 1, 0, 0);
    access(32'h200, 1, 0, 0, 0, 0, 0, 0);
    access(32'h300, 1, 0, 0, 0, 0, 0, 0);
    access(32'h400, 1, 0, 0, 0, 0, 0, 0);
    access(32'h300, 1, 0, 0, 0, 1, 0, 0);
    access(32'h000, 1, 0, 0, 0, 0, 1, 32'h100);
    access(32'h000, 1, 0, 0, 0, 1, 0, 0);
    access(32'h200, 1, 0, 0, 0, 1, 0, 0);
    wd = {8{32'h1234_5678}};
    access(32'h000, 1, 1, 32'h0000_00F0, wd, 1, 0, 0);
    access(32'h000, 1, 0, 0, 0, 1, 0, 0);
    access(32'h020, 1, 0, 0, 0, 0, 0, 0);
    access(32'h020, 1, 0, 0, 0, 1, 0, 0);

    @(negedge clk);
    hold = 1'b1;
    mem_address = 32'h500;
    mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    check("fill_started", seen, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_fill_pmem_read", pmem_read, 0);
    check("rst_fill_mem_resp", mem_resp, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0;
    hold = 1'b0;
    pq.delete();
    rq.delete();
    shadow.delete();
    repeat (2) @(negedge clk);

    access(32'h500, 1, 0, 0, 0, 0, 0, 0);
    access(32'h000, 1, 0, 0, 0, 0, 0, 0);
    access(32'h500, 1, 0, 0, 0, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
